// File: rtl/mmio_irq_ctrl.sv
// mmio_irq_ctrl: memory-mapped interrupt controller for the MIPS core.
// It has pending/mask/force registers, edge-detected external sources and a countdown timer.
module mmio_irq_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int          TIMER_W   = 32
) (
    input  logic        ph2,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    input  logic [7:0]  ext_irq,
    output logic [31:0] readdata,
    output logic        addrhit,
    output logic [7:0]  interrupts
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;
    logic [7:0] pend_q, pend_d, pend_nt, mask_q, mask_d, ext_prev_q, irq_q, w1c, frc, tset;
    logic [TIMER_W-1:0] load_q, count_q, count_d, wd_t;
    logic [4:0] ctrl_q;
    logic [2:0] off;
    logic wr, wr_load, wr_ctrl, timer_set, unused_ok;

    assign off        = dataadr[4:2];
    assign addrhit    = dataadr[31:5] == BASE_ADDR[31:5] && off <= 3'd5;
    assign wr         = memwrite && addrhit;
    assign wr_load    = wr && off == 3'd3;
    assign wr_ctrl    = wr && off == 3'd4;
    assign wd_t       = writedata[TIMER_W-1:0];
    assign interrupts = irq_q;
    assign unused_ok  = ^{dataadr[1:0], writedata};

    always_comb begin
        readdata = '0;
        if (addrhit)
            case (off)
                3'd0:    readdata = {24'd0, pend_q};
                3'd1:    readdata = {24'd0, mask_q};
                3'd3:    readdata = 32'(load_q);
                3'd4:    readdata = {27'd0, ctrl_q};
                3'd5:    readdata = 32'(count_q);
                default: readdata = '0;
            endcase
    end

    assign w1c     = wr && off == 3'd0 ? writedata[7:0] : '0;
    assign frc     = wr && off == 3'd2 ? writedata[7:0] : '0;
    assign mask_d  = wr && off == 3'd1 ? writedata[7:0] : mask_q;
    assign tset    = timer_set ? 8'd1 << ctrl_q[4:2] : '0;
    assign pend_nt = (pend_q & ~w1c) | (ext_irq & ~ext_prev_q) | frc;
    assign pend_d  = pend_nt | tset;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        timer_set = 1'b0;
        if (wr_load) begin
            count_d = wd_t;
            state_d = ctrl_q[0] && wd_t != '0 ? RUN : IDLE;
        end else if (wr_ctrl && !writedata[0]) begin
            state_d = IDLE;
        end else if (state_q == RUN) begin
            if (count_q == TIMER_W'(1)) begin
                timer_set = 1'b1;
                count_d   = ctrl_q[1] ? load_q : '0;
                state_d   = ctrl_q[1] && load_q != '0 ? RUN : IDLE;
            end else if (count_q == '0) begin
                state_d = IDLE;
            end else begin
                count_d = count_q - TIMER_W'(1);
            end
        end else if (wr_ctrl && !ctrl_q[0] && count_q != '0) begin
            state_d = RUN;
        end
    end

    // Timer expiries land in PEND first and reach interrupts one edge later.
    always_ff @(posedge ph2 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            mask_q     <= '0;
            ext_prev_q <= '0;
            irq_q      <= '0;
            load_q     <= '0;
            count_q    <= '0;
            ctrl_q     <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            ext_prev_q <= ext_irq;
            irq_q      <= pend_nt & mask_d;
            count_q    <= count_d;
            if (wr_load) load_q <= wd_t;
            if (wr_ctrl) ctrl_q <= writedata[4:0];
        end
    end
endmodule
